// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front end for a word-addressed RAM: alignment checks, load extraction, sub-word read-modify-write.
// Optional feature macro MAU_BOUNDS_CHECK_EN rejects byte addresses beyond the RAM's 2^ADDR_WIDTH words.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic [31:0] ram_address,
    output logic [31:0] ram_data_in,
    output logic        ram_write_enable,
    output logic        ram_read_enable,
    input  logic [31:0] ram_data_out
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        WRITE     = 3'd2,
        RMW_READ  = 3'd3,
        RMW_WRITE = 3'd4
    } state_e;

`ifdef MAU_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    state_e      state_q;
    logic        ready_q;
    logic        resp_valid_q;
    logic        resp_error_q;
    logic [31:0] resp_rdata_q;
    logic [31:0] ram_address_q;
    logic [31:0] ram_data_in_q;
    logic        rd_en_q;
    logic        wr_en_q;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [15:0] wdata_q;

    logic        accept_s;
    logic        misaligned_s;
    logic        out_of_range_s;
    logic        reject_s;
    logic [31:0] load_word_d;
    logic [31:0] merge_word_d;

    // Little-endian lane select plus optional sign extension of a RAM word.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                                 input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace one byte or halfword lane of a RAM word with right-justified store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic [15:0] data);
        logic [31:0] m;
        m = word;
        if (size == 2'b01) begin
            if (lane[1]) m[31:16] = data;
            else         m[15:0]  = data;
        end else begin
            case (lane)
                2'd0:    m[7:0]   = data[7:0];
                2'd1:    m[15:8]  = data[7:0];
                2'd2:    m[23:16] = data[7:0];
                2'd3:    m[31:24] = data[7:0];
                default: m[7:0]   = data[7:0];
            endcase
        end
        return m;
    endfunction

    assign accept_s       = req_valid && req_ready;
    assign misaligned_s   = (req_size == 2'b11) ||
                            ((req_size == 2'b01) && req_addr[0]) ||
                            ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign out_of_range_s = BOUNDS_EN && ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign reject_s       = misaligned_s || out_of_range_s;
    assign load_word_d    = load_extract(ram_data_out, lane_q, size_q, signed_q);
    assign merge_word_d   = store_merge(ram_data_out, lane_q, size_q, wdata_q);

    // Request FSM; every output is registered and set up one cycle ahead of the state that uses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ready_q       <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_error_q  <= 1'b0;
            resp_rdata_q  <= 32'd0;
            ram_address_q <= 32'd0;
            ram_data_in_q <= 32'd0;
            rd_en_q       <= 1'b0;
            wr_en_q       <= 1'b0;
            lane_q        <= 2'd0;
            size_q        <= 2'd0;
            signed_q      <= 1'b0;
            wdata_q       <= 16'd0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        ram_address_q <= {2'b00, req_addr[31:2]};
                        lane_q        <= req_addr[1:0];
                        size_q        <= req_size;
                        signed_q      <= req_signed;
                        wdata_q       <= req_wdata[15:0];
                        if (reject_s) begin
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                            resp_rdata_q <= 32'd0;
                        end else if (!req_write) begin
                            state_q <= READ;
                            ready_q <= 1'b0;
                            rd_en_q <= 1'b1;
                        end else if (req_size == 2'b10) begin
                            state_q       <= WRITE;
                            ready_q       <= 1'b0;
                            wr_en_q       <= 1'b1;
                            ram_data_in_q <= req_wdata;
                        end else begin
                            state_q <= RMW_READ;
                            ready_q <= 1'b0;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    resp_rdata_q <= load_word_d;
                    resp_valid_q <= 1'b1;
                    state_q      <= IDLE;
                    ready_q      <= 1'b1;
                end
                WRITE: begin
                    resp_rdata_q <= 32'd0;
                    resp_valid_q <= 1'b1;
                    state_q      <= IDLE;
                    ready_q      <= 1'b1;
                end
                RMW_READ: begin
                    ram_data_in_q <= merge_word_d;
                    wr_en_q       <= 1'b1;
                    state_q       <= RMW_WRITE;
                end
                RMW_WRITE: begin
                    resp_rdata_q <= 32'd0;
                    resp_valid_q <= 1'b1;
                    state_q      <= IDLE;
                    ready_q      <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready        = ready_q & rst_n;
    assign resp_valid       = resp_valid_q;
    assign resp_error       = resp_error_q;
    assign resp_rdata       = resp_rdata_q;
    assign ram_address      = ram_address_q;
    assign ram_data_in      = ram_data_in_q;
    assign ram_write_enable = wr_en_q;
    assign ram_read_enable  = rd_en_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-level reference model against a word RAM driven by the DUT.
module tb_mem_access_unit;

    localparam int AW = 14;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata, ram_address, ram_data_in, ram_data_out;
    logic        ram_write_enable, ram_read_enable;

    logic [31:0] mem     [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];
    logic        bd_we;
    logic [13:0] bd_idx;
    logic [31:0] bd_data;

    int n_chk = 0;
    int n_pass = 0;

    mem_access_unit #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_write_enable(ram_write_enable), .ram_read_enable(ram_read_enable),
        .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Word RAM: combinational read, write on rising edge; backdoor port for setup.
    assign ram_data_out = mem[ram_address[AW-1:0]];
    always @(posedge clk) begin
        if (ram_write_enable === 1'b1) mem[ram_address[AW-1:0]] <= ram_data_in;
        else if (bd_we) mem[bd_idx] <= bd_data;
    end

    function automatic bit exp_err(input logic [1:0] sz, input logic [31:0] a);
        bit e;
        e = (sz == 2'd3) || (sz == 2'd1 && a[0] == 1'b1) || (sz == 2'd2 && a % 4 != 0);
`ifdef MAU_BOUNDS_CHECK_EN
        if (a >= (32'd1 << (AW + 2))) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] a,
                                               input logic [1:0] sz, input bit sg);
        logic [31:0] v;
        v = word >> (8 * (a % 4));
        if (sz == 2'd0) begin
            v = v & 32'h0000_00FF;
            if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = v & 32'h0000_FFFF;
            if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [31:0] a,
                                                input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] mask;
        int          sh;
        sh   = 8 * (a % 4);
        mask = (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        mask = mask << sh;
        return (word & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic poke(input int idx, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = idx[13:0]; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
        ref_mem[idx] = d;
    endtask

    // Issues one request and returns at the negedge of its response cycle (or after a timeout).
    task automatic do_req(input bit b2b, input bit w, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic err, output logic [31:0] rd,
                          output int n_rd, output int n_wr);
        if (!b2b) @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        n_rd = 0; n_wr = 0;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 10) begin
            n_rd += (ram_read_enable === 1'b1) ? 1 : 0;
            n_wr += (ram_write_enable === 1'b1) ? 1 : 0;
            @(negedge clk);
            lat++;
        end
        n_rd += (ram_read_enable === 1'b1) ? 1 : 0;
        n_wr += (ram_write_enable === 1'b1) ? 1 : 0;
        err = resp_error;
        rd  = resp_rdata;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({resp_valid, resp_error, ram_read_enable, ram_write_enable} !== 4'b0000)
            $display("FAIL reset_flags got=%b exp=0000", {resp_valid, resp_error, ram_read_enable, ram_write_enable});
        else n_pass++;
        n_chk++;
        if ({resp_rdata, ram_address, ram_data_in} !== 96'd0)
            $display("FAIL reset_data rdata=%h addr=%h din=%h exp all 0", resp_rdata, ram_address, ram_data_in);
        else n_pass++;
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", req_ready);
        else n_pass++;
        for (int i = 0; i < 16; i++) poke(i, $urandom);
    endtask

    task automatic test_load();
        int lat, nr, nw; logic e; logic [31:0] rd;
        poke(4, 32'h8899_AABB);
        do_req(1'b0, 1'b0, 2'd0, 1'b1, 32'h11, 32'd0, lat, e, rd, nr, nw);
        n_chk++;
        if (lat !== 2 || e !== 1'b0 || rd !== 32'hFFFF_FFAA || nr !== 1 || nw !== 0)
            $display("FAIL load_sbyte lat=%0d err=%b rd=%h nrd=%0d nwr=%0d exp 2 0 ffffffaa 1 0", lat, e, rd, nr, nw);
        else n_pass++;
        do_req(1'b0, 1'b0, 2'd1, 1'b0, 32'h12, 32'd0, lat, e, rd, nr, nw);
        n_chk++;
        if (lat !== 2 || e !== 1'b0 || rd !== 32'h0000_8899)
            $display("FAIL load_uhalf lat=%0d err=%b rd=%h exp 2 0 00008899", lat, e, rd);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_chk++;
        if (resp_rdata !== 32'h0000_8899) $display("FAIL rdata_hold got=%h exp=00008899", resp_rdata);
        else n_pass++;
    endtask

    task automatic test_subword_store();
        int lat, nr, nw; logic e; logic [31:0] rd;
        do_req(1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_005C, lat, e, rd, nr, nw);
        n_chk++;
        if (lat !== 3 || e !== 1'b0 || rd !== 32'd0 || nr !== 1 || nw !== 1)
            $display("FAIL byte_store lat=%0d err=%b rd=%h nrd=%0d nwr=%0d exp 3 0 0 1 1", lat, e, rd, nr, nw);
        else n_pass++;
        ref_mem[4] = 32'h5C99_AABB;
        n_chk++;
        if (mem[4] !== 32'h5C99_AABB) $display("FAIL byte_store_ram got=%h exp=5c99aabb", mem[4]);
        else n_pass++;
    endtask

    task automatic test_errors();
        int lat, nr, nw; logic e; logic [31:0] rd;
        logic [31:0] addrs [3];
        logic [1:0]  sizes [3];
        bit          wrs   [3];
        addrs = '{32'h06, 32'h01, 32'h08};
        sizes = '{2'd2, 2'd1, 2'd3};
        wrs   = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, wrs[i], sizes[i], 1'b0, addrs[i], 32'hFFFF_FFFF, lat, e, rd, nr, nw);
            n_chk++;
            if (lat !== 1 || e !== 1'b1 || rd !== 32'd0 || nr !== 0 || nw !== 0)
                $display("FAIL error_%0d lat=%0d err=%b rd=%h nrd=%0d nwr=%0d exp 1 1 0 0 0", i, lat, e, rd, nr, nw);
            else n_pass++;
        end
        n_chk++;
        if (mem[0] !== ref_mem[0]) $display("FAIL error_ram got=%h exp=%h", mem[0], ref_mem[0]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat, nr, nw; logic e; logic [31:0] rd;
        do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678, lat, e, rd, nr, nw);
        ref_mem[8] = 32'h1234_5678;
        n_chk++;
        if (lat !== 2 || e !== 1'b0 || nr !== 0 || nw !== 1 || req_ready !== 1'b1)
            $display("FAIL b2b_store lat=%0d err=%b nrd=%0d nwr=%0d rdy=%b exp 2 0 0 1 1", lat, e, nr, nw, req_ready);
        else n_pass++;
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, lat, e, rd, nr, nw);
        n_chk++;
        if (lat !== 2 || e !== 1'b0 || rd !== 32'h1234_5678)
            $display("FAIL b2b_load lat=%0d err=%b rd=%h exp 2 0 12345678", lat, e, rd);
        else n_pass++;
    endtask

    task automatic test_bounds_alias();
        int lat, nr, nw; logic e; logic [31:0] rd;
        poke(0, 32'hCAFE_F00D);
        do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h0001_0000, 32'd0, lat, e, rd, nr, nw);
        n_chk++;
`ifdef MAU_BOUNDS_CHECK_EN
        if (lat !== 1 || e !== 1'b1 || nr !== 0)
            $display("FAIL bounds lat=%0d err=%b nrd=%0d exp 1 1 0", lat, e, nr);
        else n_pass++;
`else
        if (lat !== 2 || e !== 1'b0 || rd !== 32'hCAFE_F00D)
            $display("FAIL alias lat=%0d err=%b rd=%h exp 2 0 cafef00d", lat, e, rd);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_abort();
        bit seen;
        poke(8, 32'h1122_3344);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h21; req_wdata = 32'h0000_00EE;
        @(negedge clk);
        req_valid = 1'b0;
        n_chk++;
        if (ram_read_enable !== 1'b1) $display("FAIL abort_rmw_read got=%b exp=1", ram_read_enable);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({ram_read_enable, ram_write_enable, resp_valid} !== 3'b000)
            $display("FAIL abort_outputs got=%b exp=000", {ram_read_enable, ram_write_enable, resp_valid});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        n_chk++;
        if (seen || req_ready !== 1'b1 || mem[8] !== 32'h1122_3344)
            $display("FAIL abort_state resp_seen=%b rdy=%b ram=%h exp 0 1 11223344", seen, req_ready, mem[8]);
        else n_pass++;
    endtask

    task automatic test_random();
        int lat, nr, nw, idx, elat, enr, enw;
        logic e; logic [31:0] rd, erd, a, wd;
        logic [1:0] sz;
        bit w, sg, b2b, ee;
        for (int t = 0; t < 80; t++) begin
            w   = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            sg  = 1'($urandom_range(0, 1));
            b2b = 1'($urandom_range(0, 1));
            a   = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | 32'h0010_0000;
            wd  = $urandom;
            idx = int'((a >> 2) % (1 << AW));
            ee  = exp_err(sz, a);
            elat = ee ? 1 : (!w || sz == 2'd2) ? 2 : 3;
            enr  = ee ? 0 : (w && sz == 2'd2) ? 0 : 1;
            enw  = (ee || !w) ? 0 : 1;
            erd  = (ee || w) ? 32'd0 : model_load(ref_mem[idx], a, sz, sg);
            if (!ee && w) ref_mem[idx] = model_store(ref_mem[idx], a, sz, wd);
            do_req(b2b, w, sz, sg, a, wd, lat, e, rd, nr, nw);
            n_chk++;
            if (lat !== elat || e !== ee || rd !== erd || nr !== enr || nw !== enw)
                $display("FAIL rand_%0d a=%h sz=%0d w=%b got lat=%0d err=%b rd=%h nrd=%0d nwr=%0d exp %0d %b %h %0d %0d",
                         t, a, sz, w, lat, e, rd, nr, nw, elat, ee, erd, enr, enw);
            else n_pass++;
        end
        for (int i = 0; i < 16; i++) begin
            n_chk++;
            if (mem[i] !== ref_mem[i]) $display("FAIL rand_ram_%0d got=%h exp=%h", i, mem[i], ref_mem[i]);
            else n_pass++;
        end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        bd_we = 1'b0; bd_idx = 14'd0; bd_data = 32'd0;
        test_reset();
        test_load();
        test_subword_store();
        test_errors();
        test_back_to_back();
        test_bounds_alias();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
